riscv_dmem_responder: RTL and testbench
=======================================

// Module: riscv_dmem_responder
// PURPOSE
//  Data-memory responder that answers the CPU MEM stage's load/store requests.
//  - Single-port word array with byte-lane writes.
//  - Decodes funct3 itself (LB/LH/LW/LBU/LHU, SB/SH/SW) for lane select, sign/zero extension and alignment checks.
//  - Request/grant/response handshake, one outstanding request, configurable wait states.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; valid byte addresses 0 .. 4*DEPTH_WORDS-1
//  WAIT_CYCLES  1     extra cycles between grant and response (0..15)
//  DATA_WIDTH   32    data width (riscv_cpu_pkg::DATA_WIDTH); only 32 supported
// PORTS
//  clk        in   1   clock; all logic on rising edge
//  rst        in   1   reset, synchronous, active-high
//  req_i      in   1   request valid; held high with fields stable until gnt_o
//  we_i       in   1   1 = store, 0 = load
//  funct3_i   in   3   load/store funct3 encoding from riscv_cpu_pkg
//  addr_i     in   32  byte address
//  wdata_i    in   32  store data; the lane source is always wdata_i[7:0] / [15:0] / [31:0]
//  gnt_o      out  1   request accepted this cycle
//  rvalid_o   out  1   response valid, 1-cycle pulse
//  rdata_o    out  32  extended load data; 0 for stores and for errors
//  err_o      out  1   response is an error; qualified by rvalid_o
// BEHAVIOUR
//  Reset
//  - State IDLE, wait counter 0; rvalid_o, rdata_o and err_o are 0.
//  - gnt_o is 0 in the reset cycle.
//  - Array contents are not reset.
//  FSM: IDLE -> WAIT -> RESP -> IDLE
//  - IDLE: gnt_o = req_i (combinational).
//    - On grant, latch we, funct3, addr and wdata; load counter with WAIT_CYCLES.
//    - Next state is WAIT, or RESP if WAIT_CYCLES == 0.
//  - WAIT: decrement counter each cycle; move to RESP on the cycle the counter reaches 1.
//  - RESP: rvalid_o = 1 for exactly one cycle with rdata_o/err_o valid; then IDLE.
//  - gnt_o = 0 in WAIT and RESP. No request is accepted in RESP, so the fastest issue rate is one request per WAIT_CYCLES+2 cycles.
//  Latency
//  - Grant at cycle T gives rvalid_o at T+1+WAIT_CYCLES.
//  - rvalid_o, rdata_o and err_o are registered; they return to 0 in the cycle after RESP.
//  Errors (err_o = 1, rdata_o = 0, no array write)
//  - Misaligned: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0.
//  - Illegal funct3: load 011/110/111; store 011..111.
//  - Out of range: addr[31:2] >= DEPTH_WORDS.
//  Loads (word = array[addr[31:2]])
//  - LB/LBU: byte addr[1:0], sign-/zero-extended.
//  - LH/LHU: half addr[1], sign-/zero-extended.
//  - LW: full word.
//  Stores
//  - Byte enables: SB -> lane addr[1:0]; SH -> lanes {addr[1],0..1}; SW -> all 4 lanes.
//  - The array is written at the rising edge that ends the RESP cycle, only if err = 0.
//  - A load issued right after a store observes the stored data.
//  Reset mid-operation
//  - rst in WAIT or RESP aborts the request: no rvalid_o, no array write; state is IDLE.
// TESTING
//  1. W=1: SW 0xDEADBEEF @0x10 (gnt at T) -> rvalid at T+2, err=0; LW @0x10 -> 0xDEADBEEF.
//  2. SB wdata=0x80 @0x13 -> LB @0x13 = 0xFFFFFF80; LBU @0x13 = 0x00000080; LW @0x10 = 0x80ADBEEF.
//  3. SH 0x1234 @0x12 -> LHU @0x12 = 0x00001234; LH @0x10 = 0xFFFFBEEF; LW @0x10 = 0x1234BEEF.
//  4. LW @0x11 and SH @0x13 -> err=1, rdata=0; LW @0x10 still 0x1234BEEF.
//     funct3=011 load -> err=1.
//  5. LW @4*DEPTH_WORDS -> err=1.
//     W=0: grant at T, rvalid at T+1.
//     req held high continuously -> gnt pulses every W+2 cycles.
//  6. SW 0x55 @0x20, rst in WAIT -> no rvalid, LW @0x20 returns the prior value.
//     rst cycle -> gnt_o=0.

Source files
------------

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: data-memory slave for the CPU MEM stage.
// Single-port word array with byte-lane writes and local funct3 decode.
// IDLE -> WAIT -> RESP handshake with a configurable number of wait states.
module riscv_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // funct3 encodings shared by loads and stores (stores only use B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] mem [DEPTH_WORDS];

  logic        cur_we;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr;
  logic [31:0] word_idx;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic        misaligned, illegal, in_range;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  be;
  logic [31:0] wr_data;
  logic        do_write;

  // Next state and grant; the grant is combinational in IDLE and masked by reset
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    gnt_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_o = req_i & ~rst;
        if (gnt_o) state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT:  if (cnt_q == 4'd1) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields: live inputs while granting from IDLE, latched copy afterwards
  always_comb begin
    cur_we   = (state_q == S_IDLE) ? we_i     : lat_we;
    cur_f3   = (state_q == S_IDLE) ? funct3_i : lat_f3;
    cur_addr = (state_q == S_IDLE) ? addr_i   : lat_addr;
  end

  // Decode: alignment, legality, range, and lane extraction/extension for loads
  always_comb begin
    word_idx   = {2'b00, cur_addr[31:2]};
    in_range   = word_idx < 32'(DEPTH_WORDS);
    rd_word    = mem[word_idx[IDX_W-1:0]];
    rd_half    = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    rd_byte    = 8'h00;
    misaligned = 1'b0;
    illegal    = 1'b0;
    load_data  = 32'h0;
    case (cur_addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    case (cur_f3)
      F3_B:  load_data = {{24{rd_byte[7]}}, rd_byte};
      F3_H: begin
        misaligned = cur_addr[0];
        load_data  = {{16{rd_half[15]}}, rd_half};
      end
      F3_W: begin
        misaligned = |cur_addr[1:0];
        load_data  = rd_word;
      end
      F3_BU: begin
        illegal   = cur_we;
        load_data = {24'h0, rd_byte};
      end
      F3_HU: begin
        illegal    = cur_we;
        misaligned = cur_addr[0];
        load_data  = {16'h0, rd_half};
      end
      default: illegal = 1'b1;
    endcase
    resp_err   = misaligned | illegal | ~in_range;
    resp_rdata = (resp_err | cur_we) ? 32'h0 : load_data;
  end

  // Store lanes and byte enables from the latched request
  always_comb begin
    be      = 4'b0000;
    wr_data = lat_wdata;
    case (lat_f3)
      F3_B: begin
        be      = 4'b0001 << lat_addr[1:0];
        wr_data = {4{lat_wdata[7:0]}};
      end
      F3_H: begin
        be      = lat_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{lat_wdata[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    do_write = (state_q == S_RESP) & lat_we & ~resp_err & ~rst;
  end

  // State, wait counter and registered response
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_o <= (state_d == S_RESP);
      rdata_o  <= (state_d == S_RESP) ? resp_rdata : 32'h0;
      err_o    <= (state_d == S_RESP) & resp_err;
      case (state_q)
        S_IDLE:  if (gnt_o) cnt_q <= 4'(WAIT_CYCLES);
        S_WAIT:  cnt_q <= cnt_q - 4'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Capture the request fields on grant
  always_ff @(posedge clk) begin
    if (gnt_o) begin
      lat_we    <= we_i;
      lat_f3    <= funct3_i;
      lat_addr  <= addr_i;
      lat_wdata <= wdata_i;
    end
  end

  // Byte-lane array write at the edge that ends RESP
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; it maps onto plain RAM and software initialises it.
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[lat_addr[IDX_W+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Testbench for riscv_dmem_responder: two instances (WAIT_CYCLES 1 and 0),
// directed requests with a scoreboard of expected responses.
module tb_riscv_dmem_responder;

  localparam int DEPTH = 1024;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          gnt_cyc;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  int          sel;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  logic        req0, req1, gnt0, gnt1, rv0, rv1, err0, err1;
  logic [31:0] rd0, rd1;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  assign req0   = req & (sel == 0);
  assign req1   = req & (sel == 1);
  assign gnt    = (sel == 1) ? gnt1 : gnt0;
  assign rvalid = (sel == 1) ? rv1  : rv0;
  assign rdata  = (sel == 1) ? rd1  : rd0;
  assign err    = (sel == 1) ? err1 : err0;

  riscv_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .DATA_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst), .req_i(req1), .we_i(we), .funct3_i(f3), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1), .err_o(err1)
  );

  riscv_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .DATA_WIDTH(32)) dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .we_i(we), .funct3_i(f3), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt0), .rvalid_o(rv0), .rdata_o(rd0), .err_o(err0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int wait_states();
    return (sel == 1) ? 1 : 0;
  endfunction

  // One complete transaction: request, grant, scoreboard push, response pop and compare
  task automatic issue(input string tag, input logic w, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_rdata);
    logic got;
    exp_t e;
    @(negedge clk);
    req = 1'b1; we = w; f3 = fn; addr = a; wdata = d;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (gnt) begin
        got = 1'b1;
        sb.push_back('{e_err, e_rdata, cyc, tag});
      end
      @(negedge clk);
    end
    req = 1'b0;
    check({"gnt_", tag}, 32'(got), 32'd1);
    if (!got) return;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (rvalid) begin
        got = 1'b1;
        e = sb.pop_front();
        check({"rdata_", e.tag}, rdata, e.rdata);
        check({"err_", e.tag}, 32'(err), 32'(e.err));
        check({"lat_", e.tag}, 32'(cyc - e.gnt_cyc), 32'(1 + wait_states()));
      end
    end
    check({"rvalid_", tag}, 32'(got), 32'd1);
    if (!got) begin
      sb.delete();
      return;
    end
    @(negedge clk); #1;
    check({"pulse_", tag}, {rvalid, err, rdata[29:0]}, 32'h0);
  endtask

  // req held high: grants must be WAIT_CYCLES+2 apart and each response matches
  task automatic stream(input string tag, input logic [31:0] a, input logic [31:0] e_rdata);
    int grants = 0, resps = 0, last = -1;
    exp_t e;
    @(negedge clk);
    req = 1'b1; we = 1'b0; f3 = LW; addr = a; wdata = 32'h0;
    for (int i = 0; i < 40 && resps < 3; i++) begin
      #1;
      if (rvalid) begin
        resps++;
        e = sb.pop_front();
        check({"srdata_", tag}, rdata, e.rdata);
      end
      if (gnt) begin
        if (last >= 0) check({"sgap_", tag}, 32'(cyc - last), 32'(wait_states() + 2));
        last = cyc;
        grants++;
        sb.push_back('{1'b0, e_rdata, cyc, tag});
      end
      @(negedge clk);
      if (grants >= 3) req = 1'b0;
    end
    req = 1'b0;
    check({"sresps_", tag}, 32'(resps), 32'd3);
    sb.delete();
  endtask

  initial begin
    int stray;
    sel = 1; rst = 1'b1; req = 1'b1; we = 1'b0; f3 = LW; addr = 32'h0; wdata = 32'h0;

    // Reset: outputs idle, no grant even with req high
    repeat (3) @(negedge clk);
    #1;
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_err", 32'(err), 32'd0);
    rst = 1'b0; req = 1'b0;

    // Word store and load
    issue("sw_10",  1'b1, SW, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    issue("lw_10a", 1'b0, LW, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    // Byte store uses only wdata[7:0]
    issue("sb_13",  1'b1, SB, 32'h13, 32'h12345680, 1'b0, 32'h0);
    issue("lb_13",  1'b0, LB, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80);
    issue("lbu_13", 1'b0, LBU, 32'h13, 32'h0, 1'b0, 32'h00000080);
    issue("lw_10b", 1'b0, LW, 32'h10, 32'h0, 1'b0, 32'h80ADBEEF);

    // Half store uses only wdata[15:0]
    issue("sh_12",  1'b1, SH, 32'h12, 32'hABCD1234, 1'b0, 32'h0);
    issue("lhu_12", 1'b0, LHU, 32'h12, 32'h0, 1'b0, 32'h00001234);
    issue("lh_10",  1'b0, LH, 32'h10, 32'h0, 1'b0, 32'hFFFFBEEF);
    issue("lw_10c", 1'b0, LW, 32'h10, 32'h0, 1'b0, 32'h1234BEEF);

    // Misaligned and illegal: error, zero data, no write
    issue("lw_11",   1'b0, LW, 32'h11, 32'h0, 1'b1, 32'h0);
    issue("lhu_11",  1'b0, LHU, 32'h11, 32'h0, 1'b1, 32'h0);
    issue("sh_13",   1'b1, SH, 32'h13, 32'h0000FFFF, 1'b1, 32'h0);
    issue("ld_f3_3", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0);
    issue("st_f3_4", 1'b1, 3'b100, 32'h10, 32'h0, 1'b1, 32'h0);
    issue("lw_10d",  1'b0, LW, 32'h10, 32'h0, 1'b0, 32'h1234BEEF);

    // Range boundary
    issue("sw_last", 1'b1, SW, 32'(4*DEPTH-4), 32'hCAFEF00D, 1'b0, 32'h0);
    issue("lw_last", 1'b0, LW, 32'(4*DEPTH-4), 32'h0, 1'b0, 32'hCAFEF00D);
    issue("lw_oor",  1'b0, LW, 32'(4*DEPTH), 32'h0, 1'b1, 32'h0);
    issue("sw_oor",  1'b1, SW, 32'(4*DEPTH), 32'h11111111, 1'b1, 32'h0);

    // Back-to-back issue rate with W=1
    stream("w1", 32'h10, 32'h1234BEEF);

    // Zero wait states
    sel = 0;
    issue("w0_sw", 1'b1, SW, 32'h40, 32'h0BADF00D, 1'b0, 32'h0);
    issue("w0_lw", 1'b0, LW, 32'h40, 32'h0, 1'b0, 32'h0BADF00D);
    stream("w0", 32'h40, 32'h0BADF00D);

    // Reset in WAIT aborts the store
    sel = 1;
    issue("sw_20", 1'b1, SW, 32'h20, 32'h11223344, 1'b0, 32'h0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; f3 = SW; addr = 32'h20; wdata = 32'h00000055;
    #1;
    check("abort_gnt", 32'(gnt), 32'd1);
    @(negedge clk);
    rst = 1'b1; we = 1'b0; f3 = LW;
    @(negedge clk); #1;
    check("rst_cycle_gnt", 32'(gnt), 32'd0);
    check("abort_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rvalid) stray++;
      @(negedge clk);
    end
    check("abort_no_rvalid", 32'(stray), 32'd0);
    issue("lw_20", 1'b0, LW, 32'h20, 32'h0, 1'b0, 32'h11223344);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
